// File: rtl/io_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the transmit state encoding.
package uart_defs;

   localparam logic [1:0] UART_DATA   = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_CTRL   = 2'd2;
   localparam logic [1:0] UART_DIV    = 2'd3;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_MSB = 8;

   localparam int CTRL_IRQ_EN = 0;
   localparam int CTRL_TX_EN  = 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/io_uart_tx_if.sv
// demux_bus slave-side view: the shared Data lines and open-drain nIRQ are
// resolved here, both pulled up when nobody drives them.
interface demux_bus;

   logic [1:0]  Address;
   logic        RnW;
   logic        nOE;
   logic [15:0] wdata;
   logic        wdata_oe;
   logic [15:0] rdata;
   logic        rdata_oe;
   logic        irq_drive;
   wire  [15:0] Data;
   wire         nIRQ;

   assign Data = rdata_oe ? rdata : (wdata_oe ? wdata : 16'hzzzz);
   assign nIRQ = irq_drive ? 1'b0 : 1'bz;

   pullup (Data);
   pullup (nIRQ);

   modport slave  (input Address, RnW, nOE, Data, output rdata, rdata_oe, irq_drive);
   modport master (output Address, RnW, nOE, wdata, wdata_oe, input Data, nIRQ);

endinterface

// File: rtl/io_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop frees an entry on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // storage is not reset; the pointers alone define what is valid
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and the
// frame serialiser with a per-frame latched baud divisor.
//
// state | meaning
// IDLE  | line high, waiting for tx_en and a queued byte
// START | start bit (low) for bit_div+1 cycles
// DATA  | 8 data bits LSB first, bit_div+1 cycles each
// STOP  | stop bit (high), then next frame without a gap or back to IDLE
module io_uart_tx
   import uart_defs::*;
#(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd207
) (
   input  logic     Clock,
   input  logic     nReset,
   input  logic     nSel,
   demux_bus.slave  bus,
   output logic     TxD
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t   state;
   tx_state_t   state_nx;
   logic        wr_done;
   logic        stat_rd;
   logic        wr_stb;
   logic        rd_en;
   logic        overflow;
   logic        irq_en;
   logic        tx_en;
   logic [15:0] div;
   logic [15:0] bit_div;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        bit_end;
   logic        busy;
   logic        push;
   logic        pop;
   logic [7:0]  head;
   logic        full;
   logic        empty;
   logic [CW-1:0] count;
   logic [15:0] rdata;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys (Clock),
      .rst_b   (nReset),
      .push    (push),
      .wdata   (bus.Data[7:0]),
      .pop     (pop),
      .rdata   (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // a write commits once per chip-select assertion
   assign wr_stb = ~nSel & ~bus.RnW & ~wr_done;
   assign rd_en  = ~nSel & bus.RnW & ~bus.nOE;
   assign push   = wr_stb && (bus.Address == UART_DATA);

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         wr_done  <= 1'b0;
         stat_rd  <= 1'b0;
         overflow <= 1'b0;
         irq_en   <= 1'b0;
         tx_en    <= 1'b1;
         div      <= DEFAULT_DIV;
      end else begin
         wr_done <= ~nSel & (wr_done | ~bus.RnW);
         if (nSel)
            stat_rd <= 1'b0;
         else if (rd_en && (bus.Address == UART_STATUS))
            stat_rd <= 1'b1;
         if (push & full & ~pop)
            overflow <= 1'b1;
         else if (nSel & stat_rd)
            overflow <= 1'b0;
         if (wr_stb && (bus.Address == UART_CTRL)) begin
            irq_en <= bus.Data[CTRL_IRQ_EN];
            tx_en  <= bus.Data[CTRL_TX_EN];
         end
         if (wr_stb && (bus.Address == UART_DIV))
            div <= bus.Data;
      end
   end

   assign busy = (state != IDLE);

   always_comb begin
      rdata = '0;
      case (bus.Address)
         UART_STATUS: begin
            rdata[ST_BUSY]                = busy;
            rdata[ST_FULL]                = full;
            rdata[ST_EMPTY]               = empty;
            rdata[ST_OVF]                 = overflow;
            rdata[ST_CNT_MSB:ST_CNT_LSB]  = 5'(count);
         end
         UART_CTRL: begin
            rdata[CTRL_IRQ_EN] = irq_en;
            rdata[CTRL_TX_EN]  = tx_en;
         end
         UART_DIV: rdata = div;
         default:  ;
      endcase
   end

   assign bus.rdata     = rdata;
   assign bus.rdata_oe  = rd_en;
   assign bus.irq_drive = irq_en & empty & ~busy;

   assign bit_end = (bit_cnt == '0);

   always_ff @(posedge Clock) begin
      if (!nReset) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (tx_en & ~empty) begin
               pop      = 1'b1;
               state_nx = START;
            end
         end
         START: if (bit_end) state_nx = DATA;
         DATA:  if (bit_end && (bit_idx == 3'd7)) state_nx = STOP;
         STOP: begin
            if (bit_end) begin
               if (tx_en & ~empty) begin
                  pop      = 1'b1;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // divisor is captured at the pop so DIV writes only affect the next frame
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         bit_div <= '0;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else if (pop) begin
         bit_div <= div;
         bit_cnt <= div;
         bit_idx <= '0;
         shift   <= head;
      end else if (state != IDLE) begin
         if (bit_end) begin
            bit_cnt <= bit_div;
            if (state == DATA) begin
               shift   <= shift >> 1;
               bit_idx <= bit_idx + 1'b1;
            end
         end else begin
            bit_cnt <= bit_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      TxD = 1'b1;
      case (state)
         START:   TxD = 1'b0;
         DATA:    TxD = shift[0];
         default: ;
      endcase
   end

endmodule
